// File: rtl/neuron_mac_if.sv
// Handshake bundle between the neuron MAC, its x/w source and the downstream activation stage.
// The master side drives stimulus and consumes results; the slave side is the MAC.
interface neuron_mac_if;
   logic        start;
   logic [15:0] bias;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x_in;
   logic [15:0] w_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   modport master (
      output start, bias, in_valid, x_in, w_in, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  start, bias, in_valid, x_in, w_in, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/neuron_mac.sv
// Serial Q8.8 multiply-accumulate neuron: bias + sum(x*w), accumulated at Q16.16,
// saturated to 16 bits only at the output and held under a valid/ready handshake.
module neuron_mac #(
   parameter int N_INPUTS = 8,
   parameter int ACC_W    = 41
) (
   input  logic         clk,
   input  logic         rst,
   neuron_mac_if.slave  bus
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic signed [ACC_W-1:0]  acc_r;
   logic signed [ACC_W-1:0]  acc_nxt_s;
   logic [CNT_W-1:0]         cnt_r;
   logic [CNT_W-1:0]         cnt_nxt_s;
   logic                     in_ready_r;
   logic                     out_valid_r;
   logic                     busy_r;
   logic [15:0]              out_data_r;
   logic signed [31:0]       prod_s;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  bias_ext_s;
   logic signed [ACC_W-1:0]  acc_shift_s;
   logic                     load_out_s;

   // Clamp a floor-shifted accumulator to Q8.8: in range only when bits [ACC_W-1:15] agree.
   function automatic logic [15:0] sat16(input logic [ACC_W-1:0] v);
      logic [15:0] r;
      if (!v[ACC_W-1] && (|v[ACC_W-2:15])) begin
         r = 16'h7FFF;
      end else if (v[ACC_W-1] && !(&v[ACC_W-2:15])) begin
         r = 16'h8000;
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

   assign prod_s      = $signed(bus.x_in) * $signed(bus.w_in);
   assign prod_ext_s  = {{(ACC_W-32){prod_s[31]}}, prod_s};
   assign bias_ext_s  = {{(ACC_W-24){bus.bias[15]}}, bus.bias, 8'h00};
   assign acc_shift_s = acc_nxt_s >>> 4'd8;

   // Next-state, accumulator and pair-counter decode.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      cnt_nxt_s   = cnt_r;
      load_out_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = ACCUM;
               acc_nxt_s   = bias_ext_s;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_nxt_s = acc_r + prod_ext_s;
               cnt_nxt_s = cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(N_INPUTS - 1)) begin
                  state_nxt_s = DONE;
                  load_out_s  = 1'b1;
               end else begin
                  state_nxt_s = ACCUM;
               end
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs; flags are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         cnt_r       <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= 16'h0000;
      end else begin
         state_r     <= state_nxt_s;
         acc_r       <= acc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         in_ready_r  <= (state_nxt_s == ACCUM);
         out_valid_r <= (state_nxt_s == DONE);
         busy_r      <= (state_nxt_s != IDLE);
         if (load_out_s) begin
            out_data_r <= sat16(acc_shift_s);
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed-vector bench for neuron_mac (N_INPUTS=4): expected sums go into a scoreboard
// queue at stimulus time and a negedge monitor checks every consumed result.
module tb_neuron_mac;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   logic [15:0] exp_q[$];
   logic [15:0] xv[4];
   logic [15:0] wv[4];

   neuron_mac_if bus ();

   neuron_mac #(.N_INPUTS(4), .ACC_W(41)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] xs, input logic [63:0] ws);
      for (int i = 0; i < 4; i++) begin
         xv[i] = xs[16*i +: 16];
         wv[i] = ws[16*i +: 16];
      end
   endtask

   // Monitor: every accepted result is checked against the oldest expected value.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %h with empty scoreboard", bus.out_data);
         end else begin
            chk("out_data", bus.out_data, exp_q.pop_front());
         end
      end
   end

   task automatic run_eval(input logic [15:0] b, input logic [15:0] exp,
                           input bit gaps, input int stall, input bit pulse);
      exp_q.push_back(exp);
      bus.start = 1'b1;
      bus.bias  = b;
      tick();
      bus.start = 1'b0;
      chk("in_ready_after_start", {15'd0, bus.in_ready}, 16'd1);
      chk("busy_after_start", {15'd0, bus.busy}, 16'd1);
      for (int i = 0; i < 4; i++) begin
         if (gaps && i > 0) begin
            bus.in_valid = 1'b0;
            bus.x_in     = 16'h7FFF;
            bus.w_in     = 16'h7FFF;
            tick();
            tick();
         end
         if (i == 3) chk("out_valid_before_last", {15'd0, bus.out_valid}, 16'd0);
         bus.in_valid = 1'b1;
         bus.x_in     = xv[i];
         bus.w_in     = wv[i];
         if (pulse && i == 1) begin
            bus.start = 1'b1;
            bus.bias  = 16'h7FFF;
         end
         tick();
         bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("out_valid_latency", {15'd0, bus.out_valid}, 16'd1);
      chk("in_ready_in_done", {15'd0, bus.in_ready}, 16'd0);
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("out_valid_held", {15'd0, bus.out_valid}, 16'd1);
         chk("out_data_stable", bus.out_data, exp);
      end
      bus.out_ready = 1'b1;
      if (pulse) bus.start = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      chk("out_valid_after_hs", {15'd0, bus.out_valid}, 16'd0);
      chk("busy_after_hs", {15'd0, bus.busy}, 16'd0);
      tick();
      chk("idle_after_hs", {15'd0, bus.busy}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.bias      = 16'h0000;
      bus.in_valid  = 1'b0;
      bus.x_in      = 16'h0000;
      bus.w_in      = 16'h0000;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("rst_out_data", bus.out_data, 16'h0000);
      chk("rst_busy", {15'd0, bus.busy}, 16'd0);

      // Basic sum: 1.0 + 4 * (2.0 * 0.5) = 5.0
      load({4{16'h0200}}, {4{16'h0080}});
      run_eval(16'h0100, 16'h0500, 1'b0, 0, 1'b0);

      // Mixed signs: -1.0 - 3.0 + 1.0 + 1.0 + 0 = -2.0
      load({16'h0000, 16'h0100, 16'h0040, 16'h0180}, {16'h1234, 16'h0100, 16'h0400, 16'hFE00});
      run_eval(16'hFF00, 16'hFE00, 1'b0, 0, 1'b0);

      // Positive and negative saturation
      load({4{16'h7FFF}}, {4{16'h7FFF}});
      run_eval(16'h7FFF, 16'h7FFF, 1'b0, 0, 1'b0);
      load({4{16'h8000}}, {4{16'h7FFF}});
      run_eval(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

      // Floor rounding of the Q16.16 -> Q8.8 shift
      load({48'h0, 16'h0001}, {48'h0, 16'h0001});
      run_eval(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
      load({48'h0, 16'hFFFF}, {48'h0, 16'h0001});
      run_eval(16'h0000, 16'hFFFF, 1'b0, 0, 1'b0);

      // Input gaps, then output backpressure of 5 cycles
      load({4{16'h0200}}, {4{16'h0080}});
      run_eval(16'h0100, 16'h0500, 1'b1, 0, 1'b0);
      run_eval(16'h0100, 16'h0500, 1'b0, 5, 1'b0);

      // start pulsed during ACCUM and in the DONE handshake cycle
      run_eval(16'h0100, 16'h0500, 1'b0, 2, 1'b1);

      // Reset after 2 of 4 pairs, then a clean run
      bus.start = 1'b1;
      bus.bias  = 16'h0300;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.x_in     = 16'h7FFF;
         bus.w_in     = 16'h7FFF;
         tick();
      end
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("midrst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("midrst_out_data", bus.out_data, 16'h0000);
      chk("midrst_busy", {15'd0, bus.busy}, 16'd0);
      load({4{16'h0200}}, {4{16'h0080}});
      run_eval(16'h0100, 16'h0500, 1'b0, 0, 1'b0);

      tick();
      tick();
      chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Serial multiply-accumulate neuron that computes one weighted sum `bias + Σ x[i]·w[i]` in signed Q8.8 fixed point. It sits directly upstream of the sigmoid activation stage and drives that stage's 16-bit Q8.8 input. Input/weight pairs stream in one per accepted cycle. The result is saturated to 16 bits and held under a valid/ready handshake until it is consumed.

## Interface
Parameters:
- `N_INPUTS`, default 8: number of x/w pairs per neuron evaluation; legal range 1–256.
- `ACC_W`, default 41: accumulator width in bits; must be at least 32 + clog2(`N_INPUTS`) + 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin an evaluation; sampled only in IDLE.
- `bias`  input  16  signed Q8.8 bias, captured on the accepted `start`.
- `in_valid`  input  1  `x_in`/`w_in` are valid this cycle.
- `in_ready`  output  1  block accepts a pair this cycle.
- `x_in`  input  16  signed Q8.8 input activation.
- `w_in`  input  16  signed Q8.8 weight.
- `out_valid`  output  1  `out_data` holds a completed result.
- `out_ready`  input  1  downstream consumes the result.
- `out_data`  output  16  signed Q8.8 saturated sum, feeds the activation input.
- `busy`  output  1  high in ACCUM or DONE.

## Operation
- The FSM has three states: IDLE, ACCUM, DONE.
- **IDLE**
  - `start`=1 moves to ACCUM.
  - In the same cycle: acc ← sign-extend(`bias`) << 8 (Q16.16 alignment), count ← 0.
- **ACCUM**
  - `in_ready`=1.
  - A pair is accepted when `in_valid` && `in_ready`; then acc ← acc + sign-extend(`x_in`·`w_in`) and count ← count+1.
  - The product is a full signed 32-bit Q16.16 value with no truncation before accumulation.
  - Cycles with `in_valid`=0 hold all state.
  - Accepting pair number `N_INPUTS` (count = `N_INPUTS`−1) moves to DONE.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - `out_data` = sat16(acc >>> 8). The shift is arithmetic, so rounding is toward −∞.
  - sat16 clamps to the range 0x8000..0x7FFF.
  - `out_data` is registered when entering DONE and is stable for as long as `out_valid` is high.
  - `out_valid` && `out_ready` moves to IDLE.
- `start` is ignored in ACCUM and DONE, including the cycle in which the DONE handshake completes.
- The accumulator never wraps. `ACC_W` is sized for the worst case, and saturation is applied only at the output.
- `x_in`/`w_in` are don't-care whenever `in_ready`=0.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0x0000, `busy`=0; state IDLE; acc=0; count=0.
- `rst` asserted in any state returns the block to IDLE on the next edge. Any partial sum is discarded and `out_valid` drops.
- Latency:
  - `start` accepted at edge T → `in_ready`=1 in the cycle after T.
  - Final pair accepted at edge T → `out_valid`=1 in the cycle after T.
  - Minimum evaluation time is 1 + `N_INPUTS` + 1 cycles with no stalls.
- Handshake complete at edge T → `out_valid`=0 and `busy`=0 after T. The next `start` is accepted at edge T+1 at the earliest.
- `in_ready` is a pure function of state. It does not depend combinationally on `in_valid`.
- `out_valid` is a pure function of state. It does not depend combinationally on `out_ready`.

## Test plan
- **Basic sum:** `N_INPUTS`=4, `bias`=0x0100, four pairs `x`=0x0200, `w`=0x0080, no stalls → `out_data`=0x0500, `out_valid` rises exactly 1 cycle after the 4th accepted pair.
- **Saturation:**
  - Four pairs 0x7FFF·0x7FFF, `bias`=0x7FFF → `out_data`=0x7FFF.
  - Four pairs 0x8000·0x7FFF, `bias`=0x8000 → `out_data`=0x8000.
- **Floor rounding:**
  - One product 0x0001·0x0001, `bias`=0 → 0x0000.
  - One product 0xFFFF·0x0001, `bias`=0 → 0xFFFF.
- **Backpressure and gaps:**
  - `in_valid` toggled 1,0,0,1,… → sum is unchanged versus the no-gap run.
  - `out_ready` held low 5 cycles in DONE → `out_data` stable and `out_valid` held; consumed on the first `out_ready`=1.
- **Ignored start:** `start` pulsed during ACCUM and in the DONE handshake cycle → no restart and the result is unaffected; block is IDLE afterwards.
- **Reset mid-evaluation:** `rst` after 2 of 4 pairs → next cycle IDLE with all outputs 0. A fresh run then produces the correct result with no residue from the aborted run.
